dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: RAM plus GPIO/CYCLE/SCRATCH/STATUS registers,
// with a post-reset zero-fill phase during which the core is held off via Ready.
module dmem_responder #(
  parameter int          DEPTH_WORDS    = 1024,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] CYCLE_INIT     = 32'h0
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [9:0]  address_DMEM,
  input  logic [31:0] write_data_DMEM,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] data_DMEM,
  output logic        Ready,
  output logic [7:0]  gpio_out
);
  localparam int         RAM_WORDS = DEPTH_WORDS - 4;
  localparam logic [9:0] A_LASTRAM = 10'(DEPTH_WORDS - 5);
  localparam logic [9:0] A_GPIO    = 10'(DEPTH_WORDS - 4);
  localparam logic [9:0] A_CYCLE   = 10'(DEPTH_WORDS - 3);
  localparam logic [9:0] A_SCRATCH = 10'(DEPTH_WORDS - 2);
  localparam logic [9:0] A_STATUS  = 10'(DEPTH_WORDS - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [9:0]  clr_cnt_q, clr_cnt_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  gpio_q, gpio_d;
  logic        ro_err_q, ro_err_d;
  logic        clr_err_q, clr_err_d;

  logic [31:0] mem_q [RAM_WORDS];
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        ro_set, clr_set, sts_wr;
  logic        in_ram;

  assign in_ram   = (address_DMEM < A_GPIO);
  assign Ready    = (state_q == S_RUN);
  assign gpio_out = gpio_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cycle_d   = cycle_q;
    scratch_d = scratch_q;
    gpio_d    = gpio_q;
    mem_we    = 1'b0;
    mem_addr  = clr_cnt_q;
    mem_wdata = 32'h0;
    ro_set    = 1'b0;
    clr_set   = 1'b0;
    sts_wr    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        // Core traffic is dropped here; it only flags a protocol error.
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 10'd1;
        clr_set   = MemRead | MemWrite;
        if (clr_cnt_q == A_LASTRAM) state_d = S_RUN;
      end
      default: begin
        cycle_d = cycle_q + 32'd1;
        if (MemWrite) begin
          if (in_ram) begin
            mem_we    = 1'b1;
            mem_addr  = address_DMEM;
            mem_wdata = write_data_DMEM;
          end else begin
            case (address_DMEM)
              A_GPIO:    gpio_d    = write_data_DMEM[7:0];
              A_CYCLE:   ro_set    = 1'b1;
              A_SCRATCH: scratch_d = write_data_DMEM;
              A_STATUS:  sts_wr    = 1'b1;
              default: ;
            endcase
          end
        end
      end
    endcase
    // Set beats write-1-to-clear in the same cycle.
    ro_err_d  = ro_set  | (ro_err_q  & ~(sts_wr & write_data_DMEM[2]));
    clr_err_d = clr_set | (clr_err_q & ~(sts_wr & write_data_DMEM[1]));
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      clr_cnt_q <= '0;
      cycle_q   <= CYCLE_INIT;
      scratch_q <= '0;
      gpio_q    <= '0;
      ro_err_q  <= 1'b0;
      clr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cycle_q   <= cycle_d;
      scratch_q <= scratch_d;
      gpio_q    <= gpio_d;
      ro_err_q  <= ro_err_d;
      clr_err_q <= clr_err_d;
    end
  end

  // RAM has no reset path; contents are only zeroed by the CLEAR sweep.
  always_ff @(posedge CLK) begin
    if (RSTn && mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  always_comb begin
    data_DMEM = 32'h0;
    if (state_q == S_RUN && MemRead) begin
      if (in_ram) begin
        data_DMEM = mem_q[address_DMEM];
      end else begin
        case (address_DMEM)
          A_GPIO:    data_DMEM = {24'h0, gpio_q};
          A_CYCLE:   data_DMEM = cycle_q;
          A_SCRATCH: data_DMEM = scratch_q;
          A_STATUS:  data_DMEM = {29'h0, ro_err_q, clr_err_q, Ready};
          default:   data_DMEM = 32'h0;
        endcase
      end
    end
  end

endmodule
